// File: rtl/store_narrow.sv
// Sub-word store narrowing: byte/half stores read-modify-write the target word, word stores write directly.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word requests into immediate error completions.
module store_narrow #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wack
);

    // Handshakes: a request transfers on req_valid && req_ready; mem_rd / mem_wr stay high
    // until the cycle mem_rvalid / mem_wack is seen, or until the wait counter expires.
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        trap;
    logic        expired;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // The counter holds the number of strobe cycles already spent, so the strobe lasts WAIT_MAX cycles.
    assign expired = (cnt_q == 16'(WAIT_MAX - 1));

    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data;
                    size_d = req_size;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if ((req_size == 2'b11) || trap) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (req_size == 2'b10) begin
                        wdata_d = req_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem_rvalid) begin
                    wdata_d = merged;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WRITE: begin
                if (mem_wack) begin
                    state_d = S_DONE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_DONE) && err_q;
        mem_rd    = (state_q == S_READ);
        mem_wr    = (state_q == S_WRITE);
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q;
    end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Write-side counterpart to the immediate/load-data extension path. It narrows a 32-bit store operand to a byte or halfword and merges it into a word-wide data memory.
- Sub-word stores use a read-modify-write sequence; word stores are a single write.
- Sits between the datapath store stage and the word-addressed data memory port. Little-endian lane ordering.

Parameters:
- WAIT_MAX, 255: maximum cycles to wait for mem_rvalid or mem_wack before aborting with err. Legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  1  store request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_addr  input  32  byte address of store
- req_data  input  32  store operand; low byte/half used for sub-word sizes
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- busy  output  1  request in flight (any state except IDLE)
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; 1 = request aborted, memory unchanged or partially untouched
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_rd  output  1  read strobe, held until mem_rvalid
- mem_rdata  input  32  read data, valid with mem_rvalid
- mem_rvalid  input  1  read data valid
- mem_wr  output  1  write strobe, held until mem_wack
- mem_wdata  output  32  merged write word
- mem_wack  input  1  write accepted

Behaviour:
- Reset (reset=0, async): state IDLE; req_ready=1 once reset deasserts; busy, done, err, mem_rd, mem_wr = 0; mem_addr, mem_wdata = 0; wait counter = 0. Reset mid-operation abandons the transaction immediately; the bench must not expect mem_wr afterwards.
- Accept: req_valid && req_ready latches addr, data, size. Request inputs are ignored at all other times.
- States: IDLE, READ, WRITE, DONE.
  - IDLE -> READ for size 00/01.
  - IDLE -> WRITE for size 10; mem_wdata = data, no read.
  - IDLE -> DONE with err=1 for size 11; no memory access.
  - READ: mem_rd=1. On mem_rvalid, merge data and go to WRITE next cycle.
  - WRITE: mem_wr=1 and mem_wdata stable. On mem_wack, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. err is held for the same cycle only.
- Merge:
  - byte: lane = addr[1:0]; mem_wdata = rdata with bits [8*lane+7:8*lane] replaced by data[7:0].
  - half: lane = addr[1]; bits [16*lane+15:16*lane] replaced by data[15:0].
  - Upper operand bits beyond the stored size are ignored (truncation, no overflow check).
- Timeout:
  - Counter clears on entry to READ and to WRITE, then increments each cycle in those states.
  - If the counter reaches WAIT_MAX without the handshake, go to DONE with err=1 and drop the strobe.
  - A handshake arriving in the same cycle the counter hits WAIT_MAX counts as success.
- Latency with zero-wait memory (rvalid/wack in the first strobe cycle):
  - word: accept -> done = 2 cycles.
  - sub-word: accept -> done = 3 cycles.
- Back-to-back: req_ready returns the cycle after done. There is no overlap; a new accept is possible in the first IDLE cycle.
- mem_addr is held constant from accept until IDLE.
- mem_rvalid/mem_wack outside their states are ignored.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a half request with addr[0]=1, or a word request with addr[1:0]!=0, goes IDLE -> DONE with err=1 and no memory access.
- Undefined: low address bits below the access size are ignored. half uses addr[1] only; word is written at the aligned word; err is raised only by size 11 or timeout.

Test Plan:
- Word store: addr=0x100, data=0xDEADBEEF, size=10, wack on first cycle -> mem_wr with mem_addr=0x100, mem_wdata=0xDEADBEEF, no mem_rd, done 2 cycles after accept, err=0.
- Byte store: addr=0x203, data=0x000000AB, rdata=0x11223344 -> mem_wdata=0xAB223344, done 3 cycles after accept.
- Half store: addr=0x202, data=0xFFFFCAFE, rdata=0x11223344 -> mem_wdata=0xCAFE3344, mem_addr=0x200.
- Timeout: WAIT_MAX=4, byte store, mem_rvalid never asserted -> mem_rd high 4 cycles, then done=1, err=1, mem_wr never asserted.
- Misaligned half at addr=0x201:
  - MISALIGN_TRAP_EN defined -> done/err=1, no mem strobes.
  - Undefined, rdata=0x11223344, data=0x5566 -> mem_wdata=0x11225566.
- Reset in WRITE with wack withheld: reset=0 -> mem_wr, busy, done drop at once; after release req_ready=1 and size=11 request -> done with err=1 one cycle after accept.
